// File: rtl/gate_list_exec_if.sv
// Bundle between the CPU config bus / time source and the gate list executor.
// The master drives writes and time; the slave (executor) drives gate state and status.
interface gate_list_exec_if #(
    parameter int IDX_W  = 4,
    parameter int GATE_W = 8
);
    logic              cpu_wr_b;
    logic [11:0]       cpu_addr;
    logic [15:0]       cpu_data_in;
    logic [63:0]       timestamp;
    logic [GATE_W-1:0] gate_state;
    logic [IDX_W-1:0]  cur_index;
    logic              run;
    logic              cfg_err;
    logic [1:0]        fsm_state;  // debug view: 0 idle, 1 err, 2 wait, 3 run

    // Writes are unconditional strobes: one register write per clk while cpu_wr_b is low, no back-pressure.
    modport master (
        output cpu_wr_b, cpu_addr, cpu_data_in, timestamp,
        input  gate_state, cur_index, run, cfg_err, fsm_state
    );

    modport slave (
        input  cpu_wr_b, cpu_addr, cpu_data_in, timestamp,
        output gate_state, cur_index, run, cfg_err, fsm_state
    );
endinterface

// File: rtl/gate_list_exec.sv
// TSN gate control list executor: walks the programmed list once per cycle time
// against the free-running ns timestamp and drives the registered per-queue gate vector.
module gate_list_exec #(
    parameter int ENTRY_NUM = 16,
    parameter int IDX_W     = 4,
    parameter int GATE_W    = 8
) (
    input logic             clk,
    input logic             rst,
    gate_list_exec_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ERR  = 2'd1,
        S_WAIT = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              enable_q, restart_q;
    logic [GATE_W-1:0] admin_q;
    logic [IDX_W:0]    len_q;
    logic [63:0]       base_q;
    logic [31:0]       cycle_q;
    logic [GATE_W-1:0] gate_mem [ENTRY_NUM];
    logic [31:0]       ival_mem [ENTRY_NUM];

    logic [63:0]       cyc_start_q, cyc_start_d;
    logic [63:0]       ent_end_q, ent_end_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [GATE_W-1:0] cur_gate_q, cur_gate_d;
    logic [GATE_W-1:0] gate_state_q, gate_state_d;
    logic              cfg_err_q, cfg_err_d;

    logic              wr_en, ent_hit, last_entry;
    logic [11:0]       ent_off;
    logic [9:0]        ent_sel;
    logic [IDX_W-1:0]  ent_idx, nxt_idx;
    logic [63:0]       cyc_end, ts;

    assign wr_en   = ~bus.cpu_wr_b;
    assign ts      = bus.timestamp;
    assign ent_off = bus.cpu_addr - 12'h100;
    assign ent_sel = ent_off[11:2];
    assign ent_idx = ent_sel[IDX_W-1:0];
    // Entry i occupies three words at 0x100+4*i; the fourth word and indices past the table are holes.
    assign ent_hit = wr_en && (bus.cpu_addr >= 12'h100) && (ent_sel < 10'(ENTRY_NUM))
                     && (ent_off[1:0] != 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable_q  <= 1'b0;
            restart_q <= 1'b0;
            admin_q   <= '0;
            len_q     <= '0;
            base_q    <= '0;
            cycle_q   <= '0;
            for (int i = 0; i < ENTRY_NUM; i++) begin
                gate_mem[i] <= '0;
                ival_mem[i] <= '0;
            end
        end else begin
            restart_q <= 1'b0;
            if (wr_en) begin
                case (bus.cpu_addr)
                    12'h000: begin
                        enable_q  <= bus.cpu_data_in[0];
                        restart_q <= bus.cpu_data_in[1];
                    end
                    12'h001: admin_q        <= bus.cpu_data_in[GATE_W-1:0];
                    12'h002: len_q          <= bus.cpu_data_in[IDX_W:0];
                    12'h004: base_q[15:0]   <= bus.cpu_data_in;
                    12'h005: base_q[31:16]  <= bus.cpu_data_in;
                    12'h006: base_q[47:32]  <= bus.cpu_data_in;
                    12'h007: base_q[63:48]  <= bus.cpu_data_in;
                    12'h008: cycle_q[15:0]  <= bus.cpu_data_in;
                    12'h009: cycle_q[31:16] <= bus.cpu_data_in;
                    default: ;
                endcase
            end
            if (ent_hit) begin
                case (ent_off[1:0])
                    2'd0:    gate_mem[ent_idx]        <= bus.cpu_data_in[GATE_W-1:0];
                    2'd1:    ival_mem[ent_idx][15:0]  <= bus.cpu_data_in;
                    2'd2:    ival_mem[ent_idx][31:16] <= bus.cpu_data_in;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cyc_start_q  <= '0;
            ent_end_q    <= '0;
            idx_q        <= '0;
            cur_gate_q   <= '0;
            gate_state_q <= {GATE_W{1'b1}};
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cyc_start_q  <= cyc_start_d;
            ent_end_q    <= ent_end_d;
            idx_q        <= idx_d;
            cur_gate_q   <= cur_gate_d;
            gate_state_q <= gate_state_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign cyc_end    = cyc_start_q + {32'd0, cycle_q};
    assign nxt_idx    = idx_q + IDX_W'(1);
    // Also stop at the table end so an oversized LIST_LEN cannot wrap the index.
    assign last_entry = (({1'b0, idx_q} + (IDX_W + 1)'(1)) >= len_q)
                        || (idx_q == IDX_W'(ENTRY_NUM - 1));

    always_comb begin
        state_d     = state_q;
        cyc_start_d = cyc_start_q;
        ent_end_d   = ent_end_q;
        idx_d       = idx_q;
        cur_gate_d  = cur_gate_q;
        cfg_err_d   = cfg_err_q;
        if (!enable_q) begin
            state_d   = S_IDLE;
            idx_d     = '0;
            cfg_err_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cycle_q == 32'd0 || len_q == '0) begin
                        state_d   = S_ERR;
                        cfg_err_d = 1'b1;
                    end else begin
                        state_d     = S_WAIT;
                        cyc_start_d = base_q;
                    end
                end
                S_ERR: ;
                S_WAIT: begin
                    if (restart_q) begin
                        cyc_start_d = base_q;
                    end else if (ts < cyc_start_q) begin
                        state_d = S_WAIT;
                    end else if (ts >= cyc_end) begin
                        cyc_start_d = cyc_end;
                    end else begin
                        state_d    = S_RUN;
                        idx_d      = '0;
                        ent_end_d  = cyc_start_q + {32'd0, ival_mem[0]};
                        cur_gate_d = gate_mem[0];
                    end
                end
                S_RUN: begin
                    if (restart_q) begin
                        state_d     = S_WAIT;
                        cyc_start_d = base_q;
                        idx_d       = '0;
                    end else if (ts >= cyc_end) begin
                        cyc_start_d = cyc_end;
                        idx_d       = '0;
                        ent_end_d   = cyc_end + {32'd0, ival_mem[0]};
                        cur_gate_d  = gate_mem[0];
                    end else if (ts >= ent_end_q && !last_entry) begin
                        idx_d      = nxt_idx;
                        ent_end_d  = ent_end_q + {32'd0, ival_mem[nxt_idx]};
                        cur_gate_d = gate_mem[nxt_idx];
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        gate_state_d = (state_q == S_RUN) ? cur_gate_q : admin_q;
    end

    assign bus.gate_state = gate_state_q;
    assign bus.cur_index  = idx_q;
    assign bus.run        = (state_q == S_RUN);
    assign bus.cfg_err    = cfg_err_q;
    assign bus.fsm_state  = state_q;

endmodule
